// File: rtl/nrisc_ula_mdu.sv
// NRISC registered ALU with iterative unsigned multiply/divide and valid/busy/done handshake.
// Optional overflow flag (ULA_flags[3] = V) is compiled in with `define ULA_OVF_FLAG_EN.
module nrisc_ula_mdu #(
  parameter  int TAM   = 16,
  localparam int CNT_W = $clog2(TAM) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TAM-1:0] ULA_A,
  input  logic [TAM-1:0] ULA_B,
  input  logic [3:0]     ULA_ctrl,
  input  logic           ULA_valid,
  output logic           ULA_busy,
  output logic           ULA_done,
  output logic [TAM-1:0] ULA_OUT,
  output logic [TAM-1:0] ULA_HI,
`ifdef ULA_OVF_FLAG_EN
  output logic [3:0]     ULA_flags
`else
  output logic [2:0]     ULA_flags
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*TAM-1:0]   acc_q, acc_d;
  logic [TAM-1:0]     a_q, a_d, b_q, b_d;
  logic [TAM-1:0]     out_q, out_d, hi_q, hi_d;
  logic [2:0]         nzc_q, nzc_d;
  logic               done_q, done_d;
`ifdef ULA_OVF_FLAG_EN
  logic               v_q, v_d;
  logic               res_v;
`endif

  // Result write port shared by every path that completes an operation.
  logic               wr;
  logic [TAM-1:0]     res_out, res_hi;
  logic               res_c;

  logic [TAM:0]       sum, diff;
  logic [TAM:0]       mul_sum;
  logic [TAM:0]       div_sh;

  assign sum  = {1'b0, ULA_A} + {1'b0, ULA_B};
  assign diff = {1'b0, ULA_A} - {1'b0, ULA_B};

  // Shift-add step: conditionally add A into the high half, then shift right.
  assign mul_sum = {1'b0, acc_q[2*TAM-1:TAM]} + (acc_q[0] ? {1'b0, a_q} : '0);
  // Restoring step: high half is the partial remainder, low half the shifting dividend/quotient.
  assign div_sh  = {acc_q[2*TAM-1:TAM], acc_q[TAM-1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    hi_d    = hi_q;
    nzc_d   = nzc_q;
    done_d  = 1'b0;
    wr      = 1'b0;
    res_out = '0;
    res_hi  = '0;
    res_c   = 1'b0;
`ifdef ULA_OVF_FLAG_EN
    v_d     = v_q;
    res_v   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (ULA_valid) begin
          a_d   = ULA_A;
          b_d   = ULA_B;
          cnt_d = '0;
          case (ULA_ctrl)
            4'b1000: begin
              state_d = MUL;
              acc_d   = {{TAM{1'b0}}, ULA_B};
            end
            4'b1001: begin
              state_d = DIV;
              acc_d   = {{TAM{1'b0}}, ULA_A};
            end
            default: begin
              wr = 1'b1;
              case (ULA_ctrl)
                4'b0000: begin
                  res_out = sum[TAM-1:0];
                  res_c   = sum[TAM];
`ifdef ULA_OVF_FLAG_EN
                  res_v   = (ULA_A[TAM-1] == ULA_B[TAM-1]) && (sum[TAM-1] != ULA_A[TAM-1]);
`endif
                end
                4'b0001: begin
                  res_out = diff[TAM-1:0];
                  res_c   = diff[TAM];
`ifdef ULA_OVF_FLAG_EN
                  res_v   = (ULA_A[TAM-1] != ULA_B[TAM-1]) && (diff[TAM-1] != ULA_A[TAM-1]);
`endif
                end
                4'b0010: res_out = ULA_A & ULA_B;
                4'b0011: res_out = ULA_A | ULA_B;
                4'b0100: res_out = ULA_A ^ ULA_B;
                4'b0101: begin
                  res_out = {1'b0, ULA_A[TAM-1:1]};
                  res_c   = ULA_A[0];
                end
                4'b0110: begin
                  res_out = {ULA_A[TAM-2:0], 1'b0};
                  res_c   = ULA_A[TAM-1];
                end
                4'b0111: res_out = ~ULA_A;
                4'b1101: res_out = {ULA_A[0], ULA_A[TAM-1:1]};
                4'b1110: res_out = {ULA_A[TAM-2:0], ULA_A[TAM-1]};
                default: res_out = '0;
              endcase
            end
          endcase
        end
      end

      MUL: begin
        if (cnt_q == CNT_W'(TAM)) begin
          wr      = 1'b1;
          res_out = acc_q[TAM-1:0];
          res_hi  = acc_q[2*TAM-1:TAM];
          res_c   = |acc_q[2*TAM-1:TAM];
          state_d = IDLE;
        end else begin
          acc_d = {mul_sum, acc_q[TAM-1:1]};
          cnt_d = cnt_q + 1'b1;
        end
      end

      DIV: begin
        if (b_q == '0) begin
          wr      = 1'b1;
          res_out = '1;
          res_hi  = a_q;
          res_c   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TAM)) begin
          wr      = 1'b1;
          res_out = acc_q[TAM-1:0];
          res_hi  = acc_q[2*TAM-1:TAM];
          state_d = IDLE;
        end else begin
          if (div_sh >= {1'b0, b_q}) begin
            acc_d = {div_sh[TAM-1:0] - b_q, acc_q[TAM-2:0], 1'b1};
          end else begin
            acc_d = {div_sh[TAM-1:0], acc_q[TAM-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (wr) begin
      out_d  = res_out;
      hi_d   = res_hi;
      nzc_d  = {res_out[TAM-1], (res_out == '0), res_c};
      done_d = 1'b1;
`ifdef ULA_OVF_FLAG_EN
      v_d    = res_v;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      nzc_q   <= '0;
      done_q  <= 1'b0;
`ifdef ULA_OVF_FLAG_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      nzc_q   <= nzc_d;
      done_q  <= done_d;
`ifdef ULA_OVF_FLAG_EN
      v_q     <= v_d;
`endif
    end
  end

  assign ULA_busy = (state_q != IDLE);
  assign ULA_done = done_q;
  assign ULA_OUT  = out_q;
  assign ULA_HI   = hi_q;
`ifdef ULA_OVF_FLAG_EN
  assign ULA_flags = {v_q, nzc_q};
`else
  assign ULA_flags = nzc_q;
`endif

endmodule

// File: doc/nrisc_ula_mdu.md
Name: nrisc_ula_mdu

Overview:
- Parametrised, fully registered successor ALU for the NRISC datapath.
- Keeps the existing single-cycle ALU opcode set and adds an iterative unsigned multiply/divide unit with a valid/busy/done handshake.
- Sits between the register file read ports and the writeback mux.
- The control unit stalls the pipeline while busy is high.

Parameters:
- TAM, 16: data width in bits, minimum 4.
- CNT_W, $clog2(TAM)+1: iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- ULA_A  in  TAM  operand A.
- ULA_B  in  TAM  operand B.
- ULA_ctrl  in  4  opcode.
- ULA_valid  in  1  operation request.
- ULA_busy  out  1  multi-cycle operation in progress.
- ULA_done  out  1  one-cycle pulse: ULA_OUT, ULA_HI and ULA_flags just updated.
- ULA_OUT  out  TAM  result: low product half or quotient.
- ULA_HI  out  TAM  high product half or remainder; 0 for single-cycle ops.
- ULA_flags  out  3 (4 with ULA_OVF_FLAG_EN)  {N,Z,C}, or {V,N,Z,C} when the option is compiled in.

Behaviour:
- Reset (rst=1 at a posedge, synchronous):
  - Outputs: ULA_OUT=0, ULA_HI=0, ULA_flags=0, ULA_busy=0, ULA_done=0.
  - State returns to IDLE and the counter clears.
  - Applies mid-operation: the operation is aborted, no done pulse is produced, and rst has priority over ULA_valid.
- Acceptance:
  - A request is accepted at a posedge where ULA_valid=1 and the FSM is in IDLE.
  - While busy, ULA_valid is ignored and ULA_A, ULA_B and ULA_ctrl may change freely, because operands are latched at acceptance.
- Single-cycle opcodes:
  - 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 XOR, 0101 SHR (logical, 1 bit), 0110 SHL (1 bit), 0111 NOT A, 1101 RTR (rotate right 1), 1110 RTL (rotate left 1).
  - Results appear at the acceptance edge itself (latency 1 edge).
  - ULA_done=1 for exactly the following cycle; ULA_busy stays 0.
- Multi-cycle opcodes:
  - 1000 MULU: unsigned shift-add multiply; {ULA_HI,ULA_OUT} = A*B.
  - 1001 DIVU: unsigned restoring divide; ULA_OUT = A/B, ULA_HI = A%B.
- FSM states:
  - IDLE -> MUL or DIV at acceptance: ULA_busy=1, counter=0.
  - MUL or DIV: one iteration per edge. After TAM iterations the results and flags are written and ULA_done pulses; this happens TAM+1 edges after acceptance.
  - Back to IDLE on the same edge, with ULA_busy=0.
  - A new request can be accepted on the cycle ULA_done is high (back-to-back).
- Divide by zero (B=0):
  - No iteration: the result is written at the edge after acceptance.
  - ULA_OUT = all ones, ULA_HI = A, C=1.
  - Total latency is 2 edges.
- Undefined opcodes (1010-1100, 1111):
  - Single-cycle.
  - ULA_OUT=0, ULA_HI=0, flags Z=1, others 0.
- Outputs hold their last values between operations.
- Flags, computed on the final ULA_OUT:
  - N = ULA_OUT[TAM-1].
  - Z = (ULA_OUT==0).
  - C, per opcode:
    - ADD: carry-out.
    - SUB: borrow (A<B unsigned).
    - SHR: A[0].
    - SHL: A[TAM-1].
    - MULU: ULA_HI!=0.
    - DIVU: divide-by-zero.
    - Logic ops and rotates: 0.
- Width rules:
  - All arithmetic is unsigned, modulo 2^TAM, with the exception of the V flag.
  - Internal sums are TAM+1 bits wide.
  - The product accumulator is 2*TAM bits wide.

Optional Feature:
- Macro: ULA_OVF_FLAG_EN.
- Defined:
  - ULA_flags widens to 4 bits; bit 3 is V.
  - ADD: V = (A[msb]==B[msb]) && (OUT[msb]!=A[msb]).
  - SUB: V = (A[msb]!=B[msb]) && (OUT[msb]!=A[msb]).
  - All other ops: V=0.
- Undefined:
  - ULA_flags is 3 bits and no V logic is present.
  - All other behaviour is identical.

Test Plan (TAM=16, macro undefined):
- NOT, A=0xAAAA: valid with ctrl=0111 -> next cycle ULA_OUT=0x5555, flags=000, done=1 for one cycle, busy=0.
- ADD and SHL, A=0xAAAA, B=0x5555: ctrl=0000 -> ULA_OUT=0xFFFF, flags=100. Then ctrl=0110 -> ULA_OUT=0x5554, flags=001. Back-to-back requests on consecutive cycles must both be honoured.
- MULU, A=0x0100, B=0x0300: busy=1 for 17 cycles. Toggling ULA_valid and ULA_A during busy has no effect. At done: ULA_OUT=0x0000, ULA_HI=0x0003, flags=011.
- DIVU: A=100, B=7 -> 17 cycles, ULA_OUT=14, ULA_HI=2, flags=000. Then A=5, B=0 -> done 2 edges after acceptance, ULA_OUT=0xFFFF, ULA_HI=0x0005, flags=101.
- Reset mid-operation: MULU accepted, rst=1 at iteration 5 -> next cycle busy=0, ULA_OUT=0, ULA_HI=0, flags=000, and no done pulse ever appears.
- Undefined opcode and option: ctrl=1111 -> ULA_OUT=0, flags=010. With ULA_OVF_FLAG_EN, ADD 0x7FFF+0x0001 -> ULA_OUT=0x8000, flags=1100.
